// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one imem request at a time, buffers responses in an
// output register plus a one-entry skid buffer, and handles redirects and stale-response drops.
module ifu_fetch #(
    parameter int unsigned          INS_WIDTH = 32,
    parameter logic [INS_WIDTH-1:0] RST_PC    = 32'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_redir_vld,
    input  logic [INS_WIDTH-1:0] i_redir_pc,
    output logic                 o_imem_req,
    output logic [INS_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvld,
    input  logic [INS_WIDTH-1:0] i_imem_rdata,
    output logic                 o_ins_vld,
    output logic [INS_WIDTH-1:0] o_ins,
    output logic [INS_WIDTH-1:0] o_ins_pc,
    input  logic                 i_ins_rdy,
    output logic                 o_fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_e;

    state_e                 state_q, state_d;
    logic [INS_WIDTH-1:0]   pc_q, pc_d;
    logic [INS_WIDTH-1:0]   fpc_q, fpc_d;
    logic [INS_WIDTH-1:0]   ins_q, ins_d;
    logic [INS_WIDTH-1:0]   ins_pc_q, ins_pc_d;
    logic                   ins_vld_q, ins_vld_d;
    logic [INS_WIDTH-1:0]   skid_q, skid_d;
    logic [INS_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic                   skid_vld_q, skid_vld_d;
    logic                   drop_q, drop_d;
    logic                   err_q, err_d;

    logic redir_bad;
    logic drain;
    logic req_hs;

    assign redir_bad = i_redir_vld && (i_redir_pc[1:0] != 2'b00);
    assign drain     = ins_vld_q && i_ins_rdy;
    assign req_hs    = (state_q == S_REQ) && i_imem_gnt;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        fpc_d      = fpc_q;
        ins_d      = ins_q;
        ins_pc_d   = ins_pc_q;
        ins_vld_d  = ins_vld_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        skid_vld_d = skid_vld_q;
        drop_d     = drop_q;
        err_d      = err_q;

        if (drain) begin
            ins_vld_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!err_q) state_d = S_REQ;
            end
            S_REQ: begin
                if (i_imem_gnt) begin
                    fpc_d   = pc_q;
                    pc_d    = pc_q + INS_WIDTH'(4);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvld) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!ins_vld_q || i_ins_rdy) begin
                        ins_d     = i_imem_rdata;
                        ins_pc_d  = fpc_q;
                        ins_vld_d = 1'b1;
                    end else begin
                        skid_d     = i_imem_rdata;
                        skid_pc_d  = fpc_q;
                        skid_vld_d = 1'b1;
                        state_d    = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (drain) begin
                    ins_d      = skid_q;
                    ins_pc_d   = skid_pc_q;
                    ins_vld_d  = 1'b1;
                    skid_vld_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything above: buffered instructions belong to the old path.
        if (i_redir_vld) begin
            ins_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            if (redir_bad) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else if (!err_q) begin
                pc_d = i_redir_pc;
                unique case (state_q)
                    S_REQ: begin
                        state_d = req_hs ? S_WAIT : S_REQ;
                        drop_d  = req_hs;
                    end
                    S_WAIT: begin
                        state_d = i_imem_rvld ? S_REQ : S_WAIT;
                        drop_d  = !i_imem_rvld;
                    end
                    default: state_d = S_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous) and state uses non-blocking assignments.
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RST_PC;
            fpc_q      <= RST_PC;
            ins_q      <= '0;
            ins_pc_q   <= '0;
            ins_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            ins_q      <= ins_d;
            ins_pc_q   <= ins_pc_d;
            ins_vld_q  <= ins_vld_d;
            skid_vld_q <= skid_vld_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the skid payload is left unreset on purpose; skid_vld_q qualifies it.
    always_ff @(posedge i_clk) begin
        skid_q    <= skid_d;
        skid_pc_q <= skid_pc_d;
    end

    assign o_imem_req  = (state_q == S_REQ);
    assign o_imem_addr = pc_q;
    assign o_ins_vld   = ins_vld_q;
    assign o_ins       = ins_q;
    assign o_ins_pc    = ins_pc_q;
    assign o_fetch_err = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: memory responder plus a stream-level model of the
// expected fetch addresses and delivered instruction sequence.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        i_rst_n, i_redir_vld, i_imem_gnt, i_imem_rvld, i_ins_rdy;
    logic [31:0] i_redir_pc, i_imem_rdata;
    logic        o_imem_req, o_ins_vld, o_fetch_err;
    logic [31:0] o_imem_addr, o_ins, o_ins_pc;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_redir_vld  (i_redir_vld),
        .i_redir_pc   (i_redir_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvld  (i_imem_rvld),
        .i_imem_rdata (i_imem_rdata),
        .o_ins_vld    (o_ins_vld),
        .o_ins        (o_ins),
        .o_ins_pc     (o_ins_pc),
        .i_ins_rdy    (i_ins_rdy),
        .o_fetch_err  (o_fetch_err)
    );

    int total = 0;
    int bad   = 0;

    // Model: next address the fetcher must request, next PC the IDU must receive.
    logic [31:0] m_pc, exp_pc, paddr, arm_pc;
    bit          m_err, m_kill, m_in_reset, pending, fired, rnd, hit;
    int          pcnt, n_hs, n_gnt, c_lat, arm, n;
    logic        c_rst_n, c_gnt, c_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8000_0093;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 2))
            0:       t = $urandom();
            1:       t = 32'hFFFF_FFF8;
            default: t = RST_PC + 32'($urandom_range(0, 63)) * 32'd4;
        endcase
        t[1:0] = 2'b00;
        return t;
    endfunction

    // One clock: compare outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        logic        g, r, rv, rd, rn;
        logic [31:0] rdat, rpc;
        int          lat;
        @(negedge clk);
        if (m_in_reset) begin
            check("rst_req", 32'(o_imem_req), 0);
            check("rst_addr", o_imem_addr, RST_PC);
            check("rst_vld", 32'(o_ins_vld), 0);
            check("rst_ins", o_ins, 0);
            check("rst_ins_pc", o_ins_pc, 0);
            check("rst_err", 32'(o_fetch_err), 0);
        end else begin
            check("fetch_err", 32'(o_fetch_err), 32'(m_err));
            if (m_err) begin
                check("halt_req", 32'(o_imem_req), 0);
                check("halt_vld", 32'(o_ins_vld), 0);
            end else if (o_imem_req) begin
                check("req_addr", o_imem_addr, m_pc);
                check("one_outstanding", 32'(pending), 0);
            end
            if (m_kill) begin
                check("kill_vld", 32'(o_ins_vld), 0);
            end else if (o_ins_vld) begin
                check("ins_pc", o_ins_pc, exp_pc);
                check("ins_data", o_ins, mem_word(exp_pc));
            end
        end

        rv   = 1'b0;
        rdat = $urandom();
        if (pending) begin
            if (pcnt == 0) begin
                rv   = 1'b1;
                rdat = mem_word(paddr);
            end else begin
                pcnt--;
            end
        end else if (rnd) begin
            rv = ($urandom_range(0, 7) == 0);
        end

        if (rnd) begin
            rn  = ($urandom_range(0, 399) != 0);
            g   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 3) != 0);
            lat = int'($urandom_range(0, 2));
            rd  = ($urandom_range(0, 19) == 0);
            rpc = rand_target();
        end else begin
            rn  = c_rst_n;
            g   = c_gnt;
            r   = c_rdy;
            lat = c_lat;
            rpc = arm_pc;
            case (arm)
                1:       rd = 1'b1;
                2:       rd = o_imem_req;
                3:       rd = pending && !rv;
                default: rd = 1'b0;
            endcase
            if (rd) begin
                arm   = 0;
                fired = 1'b1;
            end
        end

        i_rst_n      = rn;
        i_imem_gnt   = g;
        i_ins_rdy    = r;
        i_imem_rvld  = rv;
        i_imem_rdata = rdat;
        i_redir_vld  = rd;
        i_redir_pc   = rpc;

        if (!rn) begin
            m_in_reset = 1'b1;
            m_kill     = 1'b0;
            m_err      = 1'b0;
            pending    = 1'b0;
            m_pc       = RST_PC;
            exp_pc     = RST_PC;
        end else begin
            m_in_reset = 1'b0;
            if (o_ins_vld && r && !rd) begin
                exp_pc += 32'd4;
                n_hs++;
            end
            m_kill = rd;
            if (rd) begin
                if (rpc[1:0] != 2'b00) begin
                    m_err = 1'b1;
                end else if (!m_err) begin
                    m_pc   = rpc;
                    exp_pc = rpc;
                end
            end else if (o_imem_req && g) begin
                m_pc += 32'd4;
            end
            if (rv) pending = 1'b0;
            if (o_imem_req && g) begin
                pending = 1'b1;
                pcnt    = lat;
                paddr   = o_imem_addr;
                n_gnt++;
            end
        end
    endtask

    // what: 0 = request seen, 1 = instruction valid, 2 = armed redirect fired.
    task automatic step_until(input int what, input int bound, input string name, output int cnt);
        bit ok;
        ok  = 1'b0;
        cnt = 0;
        while (!ok && cnt < bound) begin
            step();
            cnt++;
            case (what)
                0:       ok = o_imem_req;
                1:       ok = o_ins_vld;
                default: ok = fired;
            endcase
        end
        check(name, 32'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required completion by t=1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_redir_vld = 1'b0; i_redir_pc = '0; i_imem_gnt = 1'b0;
        i_imem_rvld = 1'b0; i_imem_rdata = '0; i_ins_rdy = 1'b0;
        m_in_reset = 1'b1; m_pc = RST_PC; exp_pc = RST_PC; paddr = '0; arm_pc = '0;
        m_err = 0; m_kill = 0; pending = 0; fired = 0; rnd = 0; pcnt = 0;
        n_hs = 0; n_gnt = 0; arm = 0; c_lat = 0;
        c_rst_n = 1'b0; c_gnt = 1'b1; c_rdy = 1'b0;

        repeat (3) step();
        c_rst_n = 1'b1;

        // First fetch, then a stalled IDU filling the skid buffer.
        step_until(0, 10, "first_req_seen", n);
        check("first_req_cycle", 32'(n), 2);
        check("first_req_addr", o_imem_addr, 32'h8000_0000);
        step_until(1, 10, "first_vld_seen", n);
        check("first_ins", o_ins, 32'h0000_0093);
        check("first_ins_pc", o_ins_pc, 32'h8000_0000);
        check("second_req_addr", o_imem_addr, 32'h8000_0004);
        repeat (6) step();
        check("stall_ins", o_ins, 32'h0000_0093);
        check("stall_ins_pc", o_ins_pc, 32'h8000_0000);
        check("stall_no_req", 32'(o_imem_req), 0);
        check("stall_grants", 32'(n_gnt), 2);
        c_rdy = 1'b1;
        step();
        step();
        check("skid_vld", 32'(o_ins_vld), 1);
        check("skid_ins_pc", o_ins_pc, 32'h8000_0004);
        check("skid_ins", o_ins, 32'h0000_0097);

        // Redirect while waiting; the response lands two cycles later and is dropped.
        c_lat = 2; fired = 0; arm = 3; arm_pc = 32'h8000_0100;
        step_until(2, 20, "wait_redir_fired", n);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            check("drop_vld", 32'(o_ins_vld), 0);
            hit = o_imem_req;
        end
        check("wait_redir_req_seen", 32'(hit), 1);
        check("wait_redir_addr", o_imem_addr, 32'h8000_0100);

        // Redirect coinciding with a grant.
        c_lat = 1; fired = 0; arm = 2; arm_pc = 32'h8000_0200;
        step_until(2, 20, "req_redir_fired", n);
        step_until(0, 10, "req_redir_req_seen", n);
        check("req_redir_addr", o_imem_addr, 32'h8000_0200);
        step_until(1, 10, "req_redir_vld_seen", n);
        check("req_redir_ins_pc", o_ins_pc, 32'h8000_0200);
        check("req_redir_ins", o_ins, 32'h0000_0293);

        // Address wrap at the top of the address space.
        c_lat = 0; fired = 0; arm = 1; arm_pc = 32'hFFFF_FFFC;
        step_until(2, 5, "wrap_redir_fired", n);
        step_until(0, 10, "wrap_req_seen", n);
        check("wrap_first_addr", o_imem_addr, 32'hFFFF_FFFC);
        step_until(0, 10, "wrap_next_req_seen", n);
        check("wrap_next_addr", o_imem_addr, 32'h0000_0000);
        check("wrap_ins_vld", 32'(o_ins_vld), 1);
        check("wrap_ins_pc", o_ins_pc, 32'hFFFF_FFFC);
        check("wrap_ins", o_ins, 32'h7FFF_FF6F);

        // Misaligned redirect halts fetch until reset.
        fired = 0; arm = 1; arm_pc = 32'h8000_0102;
        step_until(2, 5, "bad_redir_fired", n);
        repeat (8) begin
            step();
            check("err_sticky", 32'(o_fetch_err), 1);
            check("err_no_req", 32'(o_imem_req), 0);
        end
        c_rst_n = 1'b0;
        step();
        step();
        check("err_cleared", 32'(o_fetch_err), 0);
        c_rst_n = 1'b1;
        step_until(0, 10, "restart_req_seen", n);
        check("restart_addr", o_imem_addr, 32'h8000_0000);

        // Randomized traffic: grants, latencies, stalls, redirects, spurious rvld, resets.
        n_hs = 0;
        rnd  = 1'b1;
        repeat (3000) step();
        rnd = 1'b0;
        c_rst_n = 1'b1;
        check("random_throughput", 32'(n_hs >= 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RST_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter INS_WIDTH, default 32: instruction and address width.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_redir_vld  input  1  redirect request (branch taken, jal, jalr) from PCU.
REQ-006 i_redir_pc  input  32  redirect target.
REQ-007 o_imem_req  output  1  instruction-memory request valid.
REQ-008 o_imem_addr  output  32  request address.
REQ-009 i_imem_gnt  input  1  request accepted this cycle (o_imem_req & i_imem_gnt = handshake).
REQ-010 i_imem_rvld  input  1  read data valid; earliest one cycle after grant.
REQ-011 i_imem_rdata  input  32  read data.
REQ-012 o_ins_vld  output  1  instruction valid toward IDU.
REQ-013 o_ins  output  32  instruction toward IDU.
REQ-014 o_ins_pc  output  32  address of o_ins.
REQ-015 i_ins_rdy  input  1  IDU consumes o_ins when o_ins_vld & i_ins_rdy.
REQ-016 o_fetch_err  output  1  sticky misaligned-redirect error.

Function
REQ-017 Internal state: fetch PC (pc), in-flight PC (fpc), output register (o_ins/o_ins_pc/o_ins_vld), one-entry skid buffer (data, pc, valid), drop flag, FSM {IDLE, REQ, WAIT, FULL}.
REQ-018 At most one outstanding memory request.
REQ-019 IDLE: o_imem_req=0; next cycle -> REQ, unless o_fetch_err=1 (stays IDLE until reset).
REQ-020 REQ: o_imem_req=1, o_imem_addr=pc; addr held stable until grant; on grant fpc<=pc, pc<=pc+4 (mod 2^32), -> WAIT.
REQ-021 WAIT: o_imem_req=0; on i_imem_rvld: drop=1 -> discard data, clear drop, -> REQ; else if output register empty or drained this cycle -> load o_ins<=rdata, o_ins_pc<=fpc, o_ins_vld<=1, -> REQ; else -> load skid, -> FULL.
REQ-022 FULL: o_imem_req=0; on o_ins_vld & i_ins_rdy: output register <= skid, skid invalid, -> REQ.
REQ-023 Output register: o_ins_vld cleared on handshake when no new data loads same cycle; o_ins/o_ins_pc hold value while o_ins_vld=1 and i_ins_rdy=0.
REQ-024 i_imem_rvld outside WAIT is ignored.
REQ-025 Redirect (i_redir_vld=1, i_redir_pc[1:0]==0), any state: pc<=i_redir_pc; output register and skid invalidated next cycle (o_ins_vld=0); redirect wins over simultaneous i_ins_rdy and simultaneous rvld.
REQ-026 Redirect in WAIT without rvld, or in REQ with grant same cycle: drop<=1, -> WAIT; pc<=i_redir_pc (not pc+4).
REQ-027 Redirect in REQ without grant: -> REQ, o_imem_addr=i_redir_pc next cycle.
REQ-028 Redirect in WAIT with rvld same cycle: data discarded, drop stays 0, -> REQ.
REQ-029 Redirect in IDLE/FULL: -> REQ next cycle (IDLE with error excepted).
REQ-030 Redirect with i_redir_pc[1:0]!=0: o_fetch_err<=1 (sticky), output/skid invalidated, -> IDLE halted; an outstanding response is still absorbed and discarded.
REQ-031 Peak throughput: one instruction per two cycles (grant in REQ, rvld next cycle).

Reset
REQ-032 While i_rst_n=0 at a rising edge: pc<=RST_PC, state IDLE, o_imem_req=0, o_imem_addr=RST_PC, o_ins_vld=0, o_ins=0, o_ins_pc=0, skid invalid, drop=0, o_fetch_err=0.
REQ-033 Reset mid-operation abandons any outstanding request; responses arriving in IDLE after reset are ignored.
REQ-034 First request asserted in the 2nd cycle after i_rst_n rises (IDLE -> REQ).

Verification
REQ-035 Reset release, gnt=1, rvld one cycle after grant with 32'h0000_0093, rdy=1 -> addr 8000_0000 then 8000_0004; o_ins=0000_0093, o_ins_pc=8000_0000.
REQ-036 rdy=0 for 6 cycles -> o_ins holds first word; second response goes to skid, FSM FULL, no third request; rdy=1 -> both delivered in order with PCs 8000_0000, 8000_0004.
REQ-037 Redirect to 8000_0100 while WAIT, response arrives 2 cycles later -> response dropped, o_ins_vld=0, next request addr 8000_0100.
REQ-038 Redirect to 8000_0200 in REQ with simultaneous grant -> response dropped; next addr 8000_0200, not 8000_0204.
REQ-039 Redirect to 8000_0102 -> o_fetch_err=1 sticky, o_imem_req stays 0 until reset; reset clears it.
REQ-040 pc=FFFF_FFFC fetch -> next addr 0000_0000 (wrap).
